acq_sequencer: RTL and testbench

//  Sequences the sample acquisition datapath from the register-file control bits.
//  - On acq_enable it flushes the sample FIFO and latches the configuration.
//  - It then issues sample strobes at the programmed divisor rate.
//  - On FIFO overflow it halts and raises a sticky flag.
//  - Sits between the normal-clock-domain register file and the sampler/FIFO.

---
 rtl/acq_sequencer_if.sv | 29 ++
 rtl/acq_sequencer.sv | 136 +++++++++++++
 tb/tb_acq_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acq_sequencer_if.sv
// acq_sequencer_if: control/status bundle between the register file, the
// sample FIFO and the acquisition sequencer.
//   master : register-file / FIFO side (drives control levels, fifo_full)
//   slave  : sequencer side (drives fifo_reset, strobes, status)
interface acq_sequencer_if #(
  parameter int DIV_WIDTH = 8
);
  logic                 acq_enable;
  logic                 acq_reset;
  logic [DIV_WIDTH-1:0] clock_divisor;
  logic [15:0]          channel_enable;
  logic                 fifo_full;
  logic                 fifo_reset;
  logic                 sample_strobe;
  logic [15:0]          channel_mask;
  logic                 running;
  logic                 overflow;
  logic [31:0]          sample_count;

  modport master (
    output acq_enable, acq_reset, clock_divisor, channel_enable, fifo_full,
    input  fifo_reset, sample_strobe, channel_mask, running, overflow, sample_count
  );

  modport slave (
    input  acq_enable, acq_reset, clock_divisor, channel_enable, fifo_full,
    output fifo_reset, sample_strobe, channel_mask, running, overflow, sample_count
  );
endinterface

// File: rtl/acq_sequencer.sv
// acq_sequencer: sequences the sample acquisition datapath.
//   IDLE -> FLUSH (fifo_reset for RESET_CYCLES) -> ARM (latch config) -> RUN
//   RUN issues one-cycle sample strobes every clock_divisor+1 cycles; a strobe
//   lost to fifo_full sets the sticky overflow flag and parks in HALT.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : acq_sequencer_if.slave (control levels in, strobes/status out)
// Optional feature: define ACQ_SAMPLE_COUNTER_EN for a saturating strobe
// counter on sample_count; otherwise sample_count is tied to 0.
module acq_sequencer #(
  parameter int RESET_CYCLES = 8,
  parameter int DIV_WIDTH    = 8
) (
  input logic            clk,
  input logic            rst,
  acq_sequencer_if.slave bus
);
  localparam int FW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FLUSH, ARM, RUN, HALT} state_t;

  state_t               state_q, state_d;
  logic [FW-1:0]        flush_cnt_q, flush_cnt_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_WIDTH-1:0] div_l_q, div_l_d;
  logic [15:0]          mask_q, mask_d;
  logic                 overflow_q, overflow_d;
  logic                 strobe_q, strobe_d;
  logic                 fifo_reset_q, fifo_reset_d;
  logic                 running_q, running_d;
  logic                 hit;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    div_cnt_d   = '0;
    div_l_d     = div_l_q;
    mask_d      = mask_q;
    overflow_d  = overflow_q;
    strobe_d    = 1'b0;
    hit         = (div_cnt_q == div_l_q);

    case (state_q)
      IDLE: begin
        flush_cnt_d = '0;
        if (bus.acq_enable && (bus.channel_enable != 16'h0)) state_d = FLUSH;
      end
      FLUSH: begin
        overflow_d  = 1'b0;
        flush_cnt_d = flush_cnt_q + FW'(1);
        if (flush_cnt_q == FLUSH_LAST) state_d = ARM;
      end
      ARM: begin
        div_l_d = bus.clock_divisor;
        mask_d  = bus.channel_enable;
        state_d = RUN;
      end
      RUN: begin
        div_cnt_d = hit ? '0 : div_cnt_q + DIV_WIDTH'(1);
        if (hit) begin
          if (bus.fifo_full) begin
            overflow_d = 1'b1;
            state_d    = HALT;
          end else begin
            strobe_d = 1'b1;
          end
        end
      end
      HALT: overflow_d = 1'b1;
      default: state_d = IDLE;
    endcase

    // Dropping enable aborts without a strobe; overflow computed above still lands.
    if (!bus.acq_enable) begin
      state_d  = IDLE;
      strobe_d = 1'b0;
    end
    if (bus.acq_reset) begin
      state_d  = IDLE;
      strobe_d = 1'b0;
    end

    fifo_reset_d = bus.acq_reset || (state_d == FLUSH);
    running_d    = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      flush_cnt_q  <= '0;
      div_cnt_q    <= '0;
      div_l_q      <= '0;
      mask_q       <= '0;
      overflow_q   <= 1'b0;
      strobe_q     <= 1'b0;
      fifo_reset_q <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      div_cnt_q    <= div_cnt_d;
      div_l_q      <= div_l_d;
      mask_q       <= mask_d;
      overflow_q   <= overflow_d;
      strobe_q     <= strobe_d;
      fifo_reset_q <= fifo_reset_d;
      running_q    <= running_d;
    end
  end

`ifdef ACQ_SAMPLE_COUNTER_EN
  logic [31:0] sample_cnt_q, sample_cnt_d;

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    if (state_q == FLUSH)                 sample_cnt_d = '0;
    else if (strobe_d && !(&sample_cnt_q)) sample_cnt_d = sample_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sample_cnt_q <= '0;
    else     sample_cnt_q <= sample_cnt_d;
  end

  assign bus.sample_count = sample_cnt_q;
`else
  assign bus.sample_count = 32'h0;
`endif

  assign bus.fifo_reset    = fifo_reset_q;
  assign bus.sample_strobe = strobe_q;
  assign bus.channel_mask  = mask_q;
  assign bus.running       = running_q;
  assign bus.overflow      = overflow_q;
endmodule

// File: tb/tb_acq_sequencer.sv
module tb_acq_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  acq_sequencer_if #(.DIV_WIDTH(8)) bus ();

  acq_sequencer #(.RESET_CYCLES(8), .DIV_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Raise enable and step until the first RUN cycle is visible (bounded).
  task automatic start_run(output bit ok);
    ok = 1'b0;
    bus.acq_enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.running) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic stop_run;
    bus.acq_enable = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset;
    bus.acq_enable = 0; bus.acq_reset = 0; bus.clock_divisor = 0;
    bus.channel_enable = 0; bus.fifo_full = 0;
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({bus.fifo_reset, bus.sample_strobe, bus.channel_mask, bus.running,
         bus.overflow, bus.sample_count} !== 52'h0) begin
      errors++;
      $display("FAIL reset_outputs: got fr=%b st=%b mask=%h run=%b ov=%b cnt=%0d, want all 0",
               bus.fifo_reset, bus.sample_strobe, bus.channel_mask, bus.running,
               bus.overflow, bus.sample_count);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    int n;
    int strobes;
    int first;
    int last;
    bit bad_gap;
    bus.clock_divisor = 8'd3;
    bus.channel_enable = 16'h00FF;
    bus.acq_enable = 1'b1;
    tick();
    checks++;
    if (bus.fifo_reset !== 1'b1) begin
      errors++; $display("FAIL flush_start: fifo_reset=%b want 1", bus.fifo_reset);
    end
    n = 0;
    while (bus.fifo_reset && n < 20) begin n++; tick(); end
    checks++;
    if (n != 8) begin
      errors++; $display("FAIL flush_len: fifo_reset high %0d cycles want 8", n);
    end
    checks++;
    if (bus.running !== 1'b0) begin
      errors++; $display("FAIL arm_running: running=%b want 0", bus.running);
    end
    tick();
    checks++;
    if (bus.running !== 1'b1 || bus.channel_mask !== 16'h00FF) begin
      errors++; $display("FAIL run_entry: running=%b mask=%h want 1/00ff", bus.running, bus.channel_mask);
    end
    // Config change mid-run must not affect the active period.
    bus.clock_divisor = 8'd7;
    bus.channel_enable = 16'hF000;
    strobes = 0; first = -1; last = 0; bad_gap = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.sample_strobe) begin
        if (first < 0) first = i;
        else if (i - last != 4) bad_gap = 1;
        last = i;
        strobes++;
      end
    end
    checks++;
    if (strobes != 3 || first != 4 || bad_gap) begin
      errors++; $display("FAIL div3_period: strobes=%0d first=%0d gapbad=%0b want 3/4/0", strobes, first, bad_gap);
    end
    checks++;
    if (bus.channel_mask !== 16'h00FF || bus.running !== 1'b1) begin
      errors++; $display("FAIL mask_stable: mask=%h running=%b want 00ff/1", bus.channel_mask, bus.running);
    end
    bus.acq_enable = 1'b0;
    tick();
    checks++;
    if (bus.running !== 1'b0 || bus.sample_strobe !== 1'b0) begin
      errors++; $display("FAIL disable_idle: running=%b strobe=%b want 0/0", bus.running, bus.sample_strobe);
    end
    tick();
  endtask

  task automatic test_rediv;
    bit ok;
    int strobes;
    int first;
    int last;
    bit bad_gap;
    start_run(ok);
    checks++;
    if (!ok || bus.channel_mask !== 16'hF000) begin
      errors++; $display("FAIL rediv_start: ok=%b mask=%h want 1/f000", ok, bus.channel_mask);
    end
    strobes = 0; first = -1; last = 0; bad_gap = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.sample_strobe) begin
        if (first < 0) first = i;
        else if (i - last != 8) bad_gap = 1;
        last = i;
        strobes++;
      end
    end
    checks++;
    if (strobes != 2 || first != 8 || bad_gap) begin
      errors++; $display("FAIL div7_period: strobes=%0d first=%0d gapbad=%0b want 2/8/0", strobes, first, bad_gap);
    end
    stop_run();
  endtask

  task automatic test_div0;
    bit ok;
    int strobes;
    bus.clock_divisor = 8'd0;
    bus.channel_enable = 16'h0001;
    start_run(ok);
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.sample_strobe) strobes++;
    end
    checks++;
    if (!ok || strobes != 10) begin
      errors++; $display("FAIL div0_every_cycle: ok=%b strobes=%0d want 1/10", ok, strobes);
    end
    checks++;
`ifdef ACQ_SAMPLE_COUNTER_EN
    if (bus.sample_count !== 32'd10) begin
      errors++; $display("FAIL sample_count: got %0d want 10", bus.sample_count);
    end
`else
    if (bus.sample_count !== 32'd0) begin
      errors++; $display("FAIL sample_count: got %0d want 0", bus.sample_count);
    end
`endif
    stop_run();
  endtask

  task automatic test_overflow;
    bit ok;
    int strobes;
    bus.clock_divisor = 8'd2;
    bus.channel_enable = 16'h0003;
    start_run(ok);
    bus.fifo_full = 1'b1;
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.sample_strobe) strobes++;
    end
    checks++;
    if (!ok || strobes != 0 || bus.overflow !== 1'b1 || bus.running !== 1'b0) begin
      errors++; $display("FAIL overflow_halt: ok=%b strobes=%0d ov=%b run=%b want 1/0/1/0",
                         ok, strobes, bus.overflow, bus.running);
    end
    bus.fifo_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.sample_strobe || bus.running) strobes++;
    end
    checks++;
    if (strobes != 0 || bus.overflow !== 1'b1) begin
      errors++; $display("FAIL halt_sticky: activity=%0d ov=%b want 0/1", strobes, bus.overflow);
    end
    bus.acq_enable = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (bus.overflow !== 1'b1 || bus.running !== 1'b0) begin
      errors++; $display("FAIL idle_overflow_hold: ov=%b run=%b want 1/0", bus.overflow, bus.running);
    end
    start_run(ok);
    checks++;
    if (!ok || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL overflow_clear: ok=%b ov=%b want 1/0", ok, bus.overflow);
    end
    stop_run();
  endtask

  task automatic test_mask_zero;
    int activity;
    bus.channel_enable = 16'h0000;
    bus.clock_divisor = 8'd0;
    bus.acq_enable = 1'b1;
    activity = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.fifo_reset || bus.sample_strobe || bus.running) activity++;
    end
    checks++;
    if (activity != 0) begin
      errors++; $display("FAIL mask_zero_idle: active cycles=%0d want 0", activity);
    end
    bus.acq_enable = 1'b0;
    tick();
  endtask

  task automatic test_acq_reset;
    bit ok;
    int fr;
    bus.channel_enable = 16'h0005;
    bus.clock_divisor = 8'd1;
    start_run(ok);
    tick();
    bus.acq_reset = 1'b1;
    fr = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.fifo_reset && !bus.running && !bus.sample_strobe) fr++;
    end
    checks++;
    if (!ok || fr != 3) begin
      errors++; $display("FAIL acq_reset_hold: ok=%b good cycles=%0d want 1/3", ok, fr);
    end
    bus.acq_enable = 1'b0;
    bus.acq_reset = 1'b0;
    tick();
    checks++;
    if (bus.fifo_reset !== 1'b0 || bus.channel_mask !== 16'h0005) begin
      errors++; $display("FAIL acq_reset_release: fr=%b mask=%h want 0/0005", bus.fifo_reset, bus.channel_mask);
    end
    tick();
  endtask

  task automatic test_async_rst;
    bit ok;
    bus.channel_enable = 16'h0101;
    bus.clock_divisor = 8'd0;
    start_run(ok);
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (!ok || {bus.fifo_reset, bus.sample_strobe, bus.channel_mask, bus.running,
                bus.overflow, bus.sample_count} !== 52'h0) begin
      errors++;
      $display("FAIL async_rst: ok=%b fr=%b st=%b mask=%h run=%b ov=%b cnt=%0d want all 0",
               ok, bus.fifo_reset, bus.sample_strobe, bus.channel_mask, bus.running,
               bus.overflow, bus.sample_count);
    end
    bus.acq_enable = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rediv();
    test_div0();
    test_overflow();
    test_mask_zero();
    test_acq_reset();
    test_async_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
